// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg: receiver FSM states and serial frame line levels, shared with the transmit side.
package serial_rx_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_rx.sv
// serial_rx: synchronizes rx and deserializes one start/data/stop frame into a word,
// with a one-cycle word strobe on a good stop bit and an error strobe on a bad one.
module serial_rx
    import serial_rx_pkg::*;
#(
    parameter int WordWidth        = 8,
    parameter int SerialTimerWidth = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic [WordWidth-1:0] word_o,
    output logic                 word_valid_o,
    output logic                 frame_err_o,
    output logic                 busy_o
);

    localparam int BitCntWidth = $clog2(WordWidth + 1);
    localparam logic [SerialTimerWidth-1:0] HalfBitM1 = SerialTimerWidth'(2 ** (SerialTimerWidth - 1) - 1);
    localparam logic [BitCntWidth-1:0] LastBit = BitCntWidth'(WordWidth - 1);

    rx_state_e                   state_q, state_d;
    logic [1:0]                  sync_q;
    logic                        prev_q;
    logic [SerialTimerWidth-1:0] timer_q, timer_d;
    logic [BitCntWidth-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WordWidth-1:0]        shift_q, shift_d;
    logic                        rx_s;

    assign rx_s   = sync_q[1];
    assign word_o = shift_q;
    assign busy_o = state_q != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= {2{IDLE_LEVEL}};
            prev_q    <= IDLE_LEVEL;
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            sync_q    <= {sync_q[0], rx_i};
            prev_q    <= rx_s;
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    // The timer runs freely and wraps, so each full wrap after the mid-start sample lands mid-bit.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q + 1'b1;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        word_valid_o = 1'b0;
        frame_err_o  = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d   = '0;
                bit_cnt_d = '0;
                if (prev_q == IDLE_LEVEL && rx_s == START_LEVEL) state_d = START;
            end
            START: if (timer_q == HalfBitM1) begin
                timer_d = '0;
                state_d = rx_s == START_LEVEL ? DATA : IDLE;
            end
            DATA: if (&timer_q) begin
                shift_d   = {rx_s, shift_q[WordWidth-1:1]};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LastBit) state_d = STOP;
            end
            STOP: if (&timer_q) begin
                state_d      = IDLE;
                word_valid_o = rx_s == STOP_LEVEL;
                frame_err_o  = rx_s != STOP_LEVEL;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/serial_rx_package.sv
// serial_rx_package: assembles 2**AddressWidth received words into a package, first word in
// the most significant slot; data changes only when a whole package has arrived.
module serial_rx_package
    import serial_rx_pkg::*;
#(
    parameter int AddressWidth     = 2,
    parameter int WordWidth        = 8,
    parameter int SerialTimerWidth = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     rx,
    output logic [(2**AddressWidth)*WordWidth-1:0]   data,
    output logic                                     valid,
    output logic                                     error,
    output logic                                     busy
);

    localparam int DataWidth = (2 ** AddressWidth) * WordWidth;

    logic [WordWidth-1:0]    word;
    logic                    word_v, frame_err;
    logic [AddressWidth-1:0] cnt_q, cnt_d, slot;
    logic [DataWidth-1:0]    pkg_q, pkg_d, data_q, data_d;
    logic                    valid_q, valid_d, error_q, error_d;

    serial_rx #(
        .WordWidth       (WordWidth),
        .SerialTimerWidth(SerialTimerWidth)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx),
        .word_o      (word),
        .word_valid_o(word_v),
        .frame_err_o (frame_err),
        .busy_o      (busy)
    );

    assign slot  = ~cnt_q;
    assign data  = data_q;
    assign valid = valid_q;
    assign error = error_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            pkg_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pkg_q   <= pkg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        pkg_d   = pkg_q;
        cnt_d   = frame_err ? '0 : cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        error_d = frame_err;
        if (word_v) begin
            pkg_d[WordWidth*int'(slot) +: WordWidth] = word;
            cnt_d   = cnt_q + 1'b1;
            valid_d = &cnt_q;
            data_d  = &cnt_q ? pkg_d : data_q;
        end
    end

endmodule

// File: doc/serial_rx_package.md
SERIAL_RX_PACKAGE -- requirements
Module: serial_rx_package

Interface
REQ-001 The module SHALL have parameter AddressWidth, default 2, log2 of the number of words per package.
REQ-002 The module SHALL have parameter WordWidth, default 8, data bits per serial frame.
REQ-003 The module SHALL have parameter SerialTimerWidth, default 8; one bit period is 2**SerialTimerWidth clk cycles.
REQ-004 The module SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 rx  input  1  asynchronous serial line, idle high.
REQ-008 data  output  2**AddressWidth*WordWidth  last complete package.
REQ-009 valid  output  1  one-cycle pulse: data updated with a new package.
REQ-010 error  output  1  one-cycle pulse: framing error detected.
REQ-011 busy  output  1  high while a frame is being received (state not IDLE).

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 Frame format SHALL be: 1 start bit (low), WordWidth data bits LSB first, 1 stop bit (high).
REQ-014 Receiver FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE -> START on a synchronized high-to-low transition of rx; bit timer cleared.
REQ-016 START SHALL wait 2**(SerialTimerWidth-1) cycles, then sample: low -> DATA; high -> IDLE (false start, no error, no state change elsewhere).
REQ-017 DATA SHALL sample each bit after a full bit period, shift it in LSB first, and go to STOP after WordWidth samples.
REQ-018 STOP SHALL sample after a full bit period and return to IDLE in the same cycle (mid stop bit), permitting back-to-back frames.
REQ-019 Stop sample high SHALL store the word into package slot (2**AddressWidth-1-wordCount) and increment wordCount; the first received word occupies the most significant slot.
REQ-020 Stop sample low SHALL assert error for one cycle, discard the word, and clear wordCount to 0 (partial package dropped).
REQ-021 When the stored word is the last slot (wordCount all ones), data SHALL load the full assembled package and valid SHALL pulse the following cycle; wordCount wraps to 0.
REQ-022 data SHALL hold its value between valid pulses; partial packages SHALL never be visible on data.
REQ-023 valid and error SHALL never be high in the same cycle.
REQ-024 Bit timer SHALL be SerialTimerWidth bits wide; bit counter SHALL be wide enough to count WordWidth.

Reset
REQ-025 rst high SHALL, at the next clk edge, force FSM to IDLE, clear timer, bit counter, wordCount, shift and assembly registers, synchronizer flops to 1.
REQ-026 Reset values: data = 0, valid = 0, error = 0, busy = 0.
REQ-027 Reset mid-frame or mid-package SHALL discard all partial data with no valid or error pulse.

Structure
REQ-028 FSM state encodings and frame constants (start/stop levels) SHALL live in a shared include header, reusable by the transmit side.
REQ-029 A single sub-module serial_rx (synchronizer, FSM, one-word output with word-strobe and frame-error strobe) SHALL be instantiated; package assembly, wordCount and outputs SHALL stay in serial_rx_package.

Verification (AddressWidth=2, WordWidth=8, SerialTimerWidth=4, 16 clk/bit)
REQ-030 Send bytes 0xDE,0xAD,0xBE,0xEF back-to-back -> exactly one valid pulse, data = 0xDEADBEEF, error never high.
REQ-031 Drive rx low for 4 cycles then high in IDLE -> busy pulses briefly, returns to IDLE, no valid, no error; following 4-byte package 0x01020304 received correctly.
REQ-032 Send 0x11, then 0x22 with stop bit low -> one error pulse, no valid; then 0xA1,0xB2,0xC3,0xD4 -> data = 0xA1B2C3D4, one valid.
REQ-033 Assert rst for 1 cycle during bit 3 of the second byte -> all outputs 0 next cycle; then 0xCA,0xFE,0xBA,0xBE -> data = 0xCAFEBABE.
REQ-034 Two consecutive packages 0x00000000 and 0xFFFFFFFF -> two valid pulses, data matches each in order, held between pulses.
